// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: word width, halt marker,
// FSM encoding and the prefetch-buffer entry layout.
package fetch_pkg;
  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] word;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fifo.sv
// Prefetch buffer: circular FIFO of {pc, word} entries with flush.
// The head is shown combinationally so a push becomes visible the next cycle.
module instr_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fetch_entry_t             push_data_i,
  input  logic                     pop_i,
  output fetch_entry_t             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int unsigned PW = $clog2(DEPTH);

  fetch_entry_t  entries_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q;
  logic          do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_o = count_q;
  assign head_o  = entries_q[rd_ptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage carries no reset; occupancy is tracked solely by the pointers.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i && !rst_i) entries_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: PC, synchronous instruction memory, FETCH/HALT FSM
// and a prefetch buffer feeding a valid/ready instruction port.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_WORDS  = 256,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  input  logic               prog_we,
  input  logic [31:0]        prog_addr,
  input  logic [31:0]        prog_data,
  input  logic               instr_ready,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  output logic               halted
);
  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [INSTR_W-1:0] mem_q [MEM_WORDS];
  logic [INSTR_W-1:0] rdata_q;
  logic [31:0]        pc_q, inflight_pc_q, rd_pc;
  logic               inflight_q;
  fetch_state_e       state_q;

  fetch_entry_t       fifo_head, fifo_push_data;
  logic [CW-1:0]      fifo_count;
  logic               fifo_full, fifo_empty;
  logic               halt_hit, space, issue, push, pop;

  // A redirect issues its target in the same cycle, so the target word is
  // pushed the next cycle and visible two cycles after the redirect.
  assign rd_pc    = redirect_valid ? {redirect_pc[31:2], 2'b00} : pc_q;
  assign halt_hit = inflight_q && (state_q == FETCH) && (rdata_q == HALT_WORD);
  assign space    = ({1'b0, fifo_count} + {{CW{1'b0}}, inflight_q}) < (CW+1)'(FIFO_DEPTH);
  assign issue    = redirect_valid || ((state_q == FETCH) && !halt_hit && space);
  assign push     = inflight_q && (state_q == FETCH) && !halt_hit && !redirect_valid;
  assign pop      = instr_valid && instr_ready;

  assign fifo_push_data = '{pc: inflight_pc_q, word: rdata_q};

  always_ff @(posedge clk) begin
    if (prog_we && !rst) mem_q[prog_addr[AW+1:2]] <= prog_data;
    rdata_q <= mem_q[rd_pc[AW+1:2]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      state_q       <= FETCH;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        inflight_pc_q <= rd_pc;
        pc_q          <= rd_pc + 32'd4;
      end
      case (state_q)
        FETCH:   if (!redirect_valid && halt_hit) state_q <= HALT;
        HALT:    if (redirect_valid) state_q <= FETCH;
        default: state_q <= FETCH;
      endcase
    end
  end

  instr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (fifo_push_data),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? '0 : fifo_head.word;
  assign instr_pc    = fifo_empty ? '0 : fifo_head.pc;
  assign halted      = (state_q == HALT);

  logic unused_bits;
  assign unused_bits = ^{redirect_pc[1:0], prog_addr[31:AW+2], prog_addr[1:0], fifo_full};
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a stream predictor checks every cycle, plus
// directed literal checks on latency, stalls, redirects, halt and wrap.
module tb_instruction_fetch;
  localparam int          MW     = 256;
  localparam logic [31:0] HALT_W = 32'hFFFF_FFFF;
  localparam logic [31:0] BASE   = 32'h1357_0000;

  logic        clk = 1'b0;
  logic        rst, redirect_valid, prog_we, instr_ready;
  logic [31:0] redirect_pc, prog_addr, prog_data;
  logic        instr_valid, halted;
  logic [31:0] instr, instr_pc;

  int   n_chk  = 0;
  int   n_pass = 0;
  logic chk_en = 1'b0;

  logic [31:0] mdl_mem [MW];
  logic [31:0] exp_pc = 32'd0;
  logic [31:0] exp_w, hold_i, hold_p;
  logic        hold_v = 1'b0;

  instruction_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .instr_ready    (instr_ready),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Stream predictor: the head must always be the next word of the straight-line
  // program from the last reset/redirect target, and nothing shows once that
  // word is the halt marker.
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      exp_w = mdl_mem[exp_pc[9:2]];
      if (exp_w == HALT_W) begin
        check("model_halt_no_valid", 32'(instr_valid), 32'd0);
      end else if (instr_valid) begin
        check("model_pc", instr_pc, exp_pc);
        check("model_word", instr, exp_w);
      end else begin
        check("model_idle_instr", instr, 32'd0);
        check("model_idle_pc", instr_pc, 32'd0);
      end
      if (hold_v) begin
        check("model_hold_valid", 32'(instr_valid), 32'd1);
        check("model_hold_instr", instr, hold_i);
        check("model_hold_pc", instr_pc, hold_p);
      end
    end
    hold_v = instr_valid && !instr_ready && !rst && !redirect_valid;
    hold_i = instr;
    hold_p = instr_pc;
    if (rst) exp_pc = 32'd0;
    else if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
    else if (instr_valid && instr_ready) exp_pc = exp_pc + 32'd4;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic nxt();
    step();
    @(negedge clk);
  endtask

  task automatic prog(input int idx, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = 32'(idx * 4);
    prog_data = d;
    mdl_mem[idx] = d;
    step();
    prog_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    @(negedge clk);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_pc", dut.pc_q, 32'd0);
    step();
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0; instr_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < MW; i++) prog(i, BASE + 32'(i));

    // Reset latency and back-to-back streaming
    instr_ready = 1'b1; chk_en = 1'b1;
    do_reset();
    @(negedge clk); check("t1_c1_valid", 32'(instr_valid), 32'd0);
    nxt();          check("t1_c2_valid", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 4; k++) begin
      nxt();
      check("t1_valid", 32'(instr_valid), 32'd1);
      check("t1_instr", instr, BASE + 32'(k));
      check("t1_pc", instr_pc, 32'(4 * k));
    end

    // Stall fills the buffer, then drains back-to-back
    instr_ready = 1'b0;
    do_reset();
    repeat (10) step();
    @(negedge clk);
    check("t2_valid", 32'(instr_valid), 32'd1);
    check("t2_instr", instr, BASE);
    check("t2_count", 32'(dut.fifo_count), 32'd4);
    check("t2_pc", dut.pc_q, 32'd16);
    step(); instr_ready = 1'b1;
    @(negedge clk); check("t2_rel_a", instr, BASE);
    for (int k = 1; k < 4; k++) begin
      nxt();
      check("t2_rel_valid", 32'(instr_valid), 32'd1);
      check("t2_rel_instr", instr, BASE + 32'(k));
    end

    // Redirect with three entries buffered
    instr_ready = 1'b0;
    do_reset();
    repeat (4) step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0042;
    @(negedge clk); check("t3_count", 32'(dut.fifo_count), 32'd3);
    step(); redirect_valid = 1'b0;
    @(negedge clk); check("t3_gap_valid", 32'(instr_valid), 32'd0);
    nxt();
    check("t3_valid", 32'(instr_valid), 32'd1);
    check("t3_pc", instr_pc, 32'h40);
    check("t3_instr", instr, BASE + 32'd16);
    step(); instr_ready = 1'b1;
    repeat (6) step();

    // Address wrap at the top of memory
    redirect_valid = 1'b1; redirect_pc = 32'h0000_03FC;
    @(negedge clk);
    step(); redirect_valid = 1'b0;
    @(negedge clk); check("t5_gap_valid", 32'(instr_valid), 32'd0);
    nxt(); check("t5_top_pc", instr_pc, 32'h3FC); check("t5_top_instr", instr, BASE + 32'd255);
    nxt(); check("t5_wrap_pc", instr_pc, 32'h400); check("t5_wrap_instr", instr, BASE);

    // Reset with two entries buffered and ready high
    step(); instr_ready = 1'b0;
    do_reset();
    repeat (3) step();
    rst = 1'b1; instr_ready = 1'b1;
    @(negedge clk); check("t6_count", 32'(dut.fifo_count), 32'd2);
    do_reset();
    @(negedge clk); check("t6_c1_valid", 32'(instr_valid), 32'd0);
    nxt();          check("t6_c2_valid", 32'(instr_valid), 32'd0);
    nxt();          check("t6_c3_pc", instr_pc, 32'd0); check("t6_c3_instr", instr, BASE);

    // Halt marker at word 2, then redirect back to 0
    step(); chk_en = 1'b0;
    prog(2, HALT_W);
    instr_ready = 1'b1; chk_en = 1'b1;
    do_reset();
    @(negedge clk);
    nxt();
    nxt(); check("t4_a", instr, BASE);
    nxt(); check("t4_b", instr, BASE + 32'd1);
    nxt(); check("t4_c5_valid", 32'(instr_valid), 32'd0); check("t4_c5_halted", 32'(halted), 32'd1);
    repeat (3) nxt();
    check("t4_c8_valid", 32'(instr_valid), 32'd0); check("t4_c8_halted", 32'(halted), 32'd1);
    step(); redirect_valid = 1'b1; redirect_pc = 32'd0;
    @(negedge clk); check("t4_redir_halted", 32'(halted), 32'd1);
    step(); redirect_valid = 1'b0;
    @(negedge clk); check("t4_resume_halted", 32'(halted), 32'd0); check("t4_resume_valid", 32'(instr_valid), 32'd0);
    nxt(); check("t4_again_pc", instr_pc, 32'd0); check("t4_again_instr", instr, BASE);
    nxt(); check("t4_again_b", instr, BASE + 32'd1);
    repeat (4) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
